ctrl_pipe_decode: RTL and testbench



---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_main_dec.sv | 70 +++++++
 rtl/ctrl_pipe_decode.sv | 158 +++++++++++++++
 tb/tb_ctrl_pipe_decode.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, ALUOp encodings, FSM states and the control bundle for the
// pipelined RV32I main-control stage.
package ctrl_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpIArith = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluBr  = 2'b01;
  localparam logic [1:0] AluR   = 2'b10;
  localparam logic [1:0] AluI   = 2'b11;

  localparam int unsigned AgeW = 3;

  typedef enum logic [1:0] {
    StRun,
    StHazard,
    StHalt
  } state_e;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       sys;
    logic       illegal;
    logic [1:0] alu_op;
  } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_main_dec.sv
// Combinational main decoder: opcode -> control bundle plus source-register
// usage flags for hazard detection.
module ctrl_main_dec
  import ctrl_pkg::*;
(
  input  logic [6:0]   opcode_i,
  output ctrl_bundle_t ctrl_o,
  output logic         rs1_used_o,
  output logic         rs2_used_o
);

  always_comb begin
    ctrl_o     = '0;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    case (opcode_i)
      OpR: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = AluR;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OpIArith: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = AluI;
        rs1_used_o       = 1'b1;
      end
      OpLoad: begin
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.alu_op     = AluAdd;
        rs1_used_o        = 1'b1;
      end
      OpStore: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = AluAdd;
        rs1_used_o       = 1'b1;
        rs2_used_o       = 1'b1;
      end
      OpBranch: begin
        ctrl_o.branch = 1'b1;
        ctrl_o.alu_op = AluBr;
        rs1_used_o    = 1'b1;
        rs2_used_o    = 1'b1;
      end
      OpLui, OpAuipc: begin
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_op    = AluAdd;
      end
      OpJal: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
      end
      OpJalr: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        rs1_used_o       = 1'b1;
      end
      OpSystem: ctrl_o.sys = 1'b1;
      default:  ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe_decode.sv
// Registered valid/ready main-control stage with load-use bubble insertion and
// ECALL/EBREAK halt. Define CTRL_PERF_CNT_EN to add stall/halt cycle counters.
module ctrl_pipe_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned ILEN       = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned ALUOP_W    = 2,
  parameter int unsigned LU_BUBBLES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               resume,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ILEN-1:0]    in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_branch,
  output logic               out_mem_read,
  output logic               out_mem_to_reg,
  output logic               out_mem_write,
  output logic               out_alu_src,
  output logic               out_reg_write,
  output logic               out_jump,
  output logic               out_sys,
  output logic               out_illegal,
  output logic [ALUOP_W-1:0] out_alu_op,
  output logic [REG_AW-1:0]  out_rd,
  output logic [REG_AW-1:0]  out_rs1,
  output logic [REG_AW-1:0]  out_rs2,
  output logic [2:0]         out_funct3,
`ifdef CTRL_PERF_CNT_EN
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_halt_cnt,
`endif
  output logic               halted
);

  ctrl_bundle_t dec, bundle_q;
  logic rs1_used, rs2_used, hazard, accept, valid_d, valid_q;
  logic [REG_AW-1:0] rd, rs1, rs2, rd_q, rs1_q, rs2_q, last_rd_d, last_rd_q;
  logic [2:0] f3_q;
  logic [AgeW-1:0] age_d, age_q;
  state_e state_q;
  logic unused_instr;

  assign rd  = REG_AW'(in_instr[11:7]);
  assign rs1 = REG_AW'(in_instr[19:15]);
  assign rs2 = REG_AW'(in_instr[24:20]);
  assign unused_instr = ^in_instr[ILEN-1:25];

  ctrl_main_dec u_dec (
    .opcode_i   (in_instr[6:0]),
    .ctrl_o     (dec),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used)
  );

  assign hazard = in_valid && (age_q != '0) && (last_rd_q != '0) &&
                  ((rs1_used && rs1 == last_rd_q) || (rs2_used && rs2 == last_rd_q));
  assign in_ready = (state_q == StRun) && !flush && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    age_d     = age_q;
    last_rd_d = last_rd_q;
    valid_d   = valid_q;
    if (flush) begin
      age_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (accept && dec.mem_read && rd != '0) begin
        age_d     = AgeW'(LU_BUBBLES);
        last_rd_d = rd;
      end else if (out_ready && age_q != '0) begin
        age_d = age_q - 1'b1;
      end
      if (accept) valid_d = 1'b1;
      else if (out_ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_q     <= '0;
      last_rd_q <= '0;
      valid_q   <= 1'b0;
      bundle_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      f3_q      <= '0;
    end else begin
      age_q     <= age_d;
      last_rd_q <= last_rd_d;
      valid_q   <= valid_d;
      if (accept) begin
        bundle_q <= dec;
        rd_q     <= rd;
        rs1_q    <= rs1;
        rs2_q    <= rs2;
        f3_q     <= in_instr[14:12];
      end
    end
  end

  // HAZARD is left as soon as the bubble count drains, so the dependent
  // instruction issues on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else if (flush) begin
      state_q <= StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (accept && dec.sys) state_q <= StHalt;
          else if (hazard && age_d != '0) state_q <= StHazard;
        end
        StHazard: if (age_d == '0) state_q <= StRun;
        StHalt:   if (resume) state_q <= StRun;
        default:  state_q <= StRun;
      endcase
    end
  end

`ifdef CTRL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_halt_cnt  <= '0;
    end else begin
      if (state_q == StHazard && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 1'b1;
      if (state_q == StHalt && perf_halt_cnt != '1) perf_halt_cnt <= perf_halt_cnt + 1'b1;
    end
  end
`endif

  assign out_valid      = valid_q;
  assign out_branch     = bundle_q.branch;
  assign out_mem_read   = bundle_q.mem_read;
  assign out_mem_to_reg = bundle_q.mem_to_reg;
  assign out_mem_write  = bundle_q.mem_write;
  assign out_alu_src    = bundle_q.alu_src;
  assign out_reg_write  = bundle_q.reg_write;
  assign out_jump       = bundle_q.jump;
  assign out_sys        = bundle_q.sys;
  assign out_illegal    = bundle_q.illegal;
  assign out_alu_op     = ALUOP_W'(bundle_q.alu_op);
  assign out_rd         = rd_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_funct3     = f3_q;
  assign halted         = (state_q == StHalt);

endmodule

// File: tb/tb_ctrl_pipe_decode.sv
// Directed bench for ctrl_pipe_decode: decode, handshake, load-use bubbles,
// halt/resume, illegal opcodes, flush and asynchronous reset.
module tb_ctrl_pipe_decode;

  logic clk = 1'b0;
  logic rst_n, flush, resume, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src;
  logic out_reg_write, out_jump, out_sys, out_illegal, halted;
  logic [1:0] out_alu_op;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [2:0] out_funct3;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [31:0] IAddi  = 32'h0050_0393;
  localparam logic [31:0] ILw    = 32'h0000_A283;
  localparam logic [31:0] IAdd   = 32'h0022_8333;
  localparam logic [31:0] IEcall = 32'h0000_0073;
  localparam logic [31:0] IBad   = 32'h0000_007F;

  ctrl_pipe_decode dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .resume         (resume),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_branch     (out_branch),
    .out_mem_read   (out_mem_read),
    .out_mem_to_reg (out_mem_to_reg),
    .out_mem_write  (out_mem_write),
    .out_alu_src    (out_alu_src),
    .out_reg_write  (out_reg_write),
    .out_jump       (out_jump),
    .out_sys        (out_sys),
    .out_illegal    (out_illegal),
    .out_alu_op     (out_alu_op),
    .out_rd         (out_rd),
    .out_rs1        (out_rs1),
    .out_rs2        (out_rs2),
    .out_funct3     (out_funct3),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // {branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump, sys, illegal}
  logic [8:0] flags;
  assign flags = {out_branch, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src,
                  out_reg_write, out_jump, out_sys, out_illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [8:0]  flags;
    logic [1:0]  alu_op;
  } vec_t;

  vec_t vecs[5] = '{
    '{32'h0062_A023, 9'b000110000, 2'b00},  // sw x6,0(x5)
    '{32'h0000_0063, 9'b100000000, 2'b01},  // beq x0,x0
    '{32'h0000_12B7, 9'b000011000, 2'b00},  // lui x5,1
    '{32'h0000_00EF, 9'b000001100, 2'b00},  // jal x1
    '{32'h0000_80E7, 9'b000011100, 2'b00}   // jalr x1,0(x1)
  };

  initial begin
    rst_n = 1'b0; flush = 1'b0; resume = 1'b0; in_valid = 1'b0; in_instr = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_flags", {23'd0, flags}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_rd", {27'd0, out_rd}, 32'd0);
    rst_n = 1'b1;
    tick();

    // addi x7,x0,5
    offer(IAddi);
    check_eq("addi_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("addi_valid", {31'd0, out_valid}, 32'd1);
    check_eq("addi_flags", {23'd0, flags}, {23'd0, 9'b000011000});
    check_eq("addi_alu_op", {30'd0, out_alu_op}, 32'd3);
    check_eq("addi_rd", {27'd0, out_rd}, 32'd7);
    tick();
    check_eq("addi_drained", {31'd0, out_valid}, 32'd0);

    // lw then dependent add, out_ready high: one bubble
    offer(ILw);
    tick();
    offer(IAdd);
    check_eq("lu_stall", {31'd0, in_ready}, 32'd0);
    check_eq("lw_flags", {23'd0, flags}, {23'd0, 9'b011011000});
    check_eq("lw_rd_rs1_f3", {21'd0, out_rd, out_rs1, out_funct3}, {21'd0, 5'd5, 5'd1, 3'd2});
    tick();
    check_eq("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
    check_eq("lu_resume_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("add_valid", {31'd0, out_valid}, 32'd1);
    check_eq("add_fields", {17'd0, out_rd, out_rs1, out_rs2}, {17'd0, 5'd6, 5'd5, 5'd2});
    check_eq("add_alu_op", {30'd0, out_alu_op}, 32'd2);
    tick();

    // lw then add with downstream stalled for three cycles
    out_ready = 1'b0;
    offer(ILw);
    tick();
    offer(IAdd);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check_eq("stall_hold_lw", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd5});
      check_eq("stall_hold_mr", {31'd0, out_mem_read}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_eq("stall_still_blocked", {31'd0, in_ready}, 32'd0);
    tick();
    check_eq("stall_bubble", {31'd0, out_valid}, 32'd0);
    check_eq("stall_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("stall_add_rd", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd6});
    tick();

    // ecall halts until resume
    offer(IEcall);
    tick();
    check_eq("ecall_sys", {23'd0, flags}, {23'd0, 9'b000000010});
    check_eq("ecall_halted", {31'd0, halted}, 32'd1);
    offer(IAddi);
    for (int i = 0; i < 5; i++) begin
      check_eq("halt_in_ready", {30'd0, halted, in_ready}, 32'd2);
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #1;
    check_eq("resume_state", {30'd0, halted, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("resume_issue", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd7});
    tick();

    // illegal opcode still presented downstream
    offer(IBad);
    tick();
    in_valid = 1'b0;
    check_eq("illegal_valid", {31'd0, out_valid}, 32'd1);
    check_eq("illegal_flags", {21'd0, flags, out_alu_op}, {21'd0, 9'b000000001, 2'b00});
    tick();

    // remaining opcode classes
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i].instr);
      tick();
      in_valid = 1'b0;
      check_eq($sformatf("vec%0d_flags", i), {21'd0, flags, out_alu_op},
               {21'd0, vecs[i].flags, vecs[i].alu_op});
      tick();
    end

    // flush while holding a load and sitting in HAZARD
    out_ready = 1'b0;
    offer(ILw);
    tick();
    offer(IAdd);
    tick();
    check_eq("flush_pre", {30'd0, out_valid, in_ready}, 32'd2);
    flush = 1'b1;
    #1;
    check_eq("flush_blocks", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check_eq("flush_cleared", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_eq("flush_add", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd6});

    // asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst", {29'd0, out_valid, halted, out_reg_write}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
